// File: rtl/l2_mem_requester_if.sv
// Bundle of request/response and memory-port signals for l2_mem_requester.
// master = the requester block, slave = cache control logic plus memory responder.
interface l2_mem_requester_if #(
   parameter int ADDR_W = 14,
   parameter int LINE_W = 128
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [LINE_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_wr;
   logic [LINE_W-1:0] resp_rdata;
   logic              resp_err;
   logic              busy;
   logic              mem_valid;
   logic              mem_rd_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_din;
   logic [LINE_W-1:0] mem_dout;
   logic              mem_ack;

   modport master (
      input  req_valid, req_wr, req_addr, req_wdata, mem_dout, mem_ack,
      output req_ready, resp_valid, resp_wr, resp_rdata, resp_err, busy,
             mem_valid, mem_rd_wr, mem_addr, mem_din
   );

   modport slave (
      output req_valid, req_wr, req_addr, req_wdata, mem_dout, mem_ack,
      input  req_ready, resp_valid, resp_wr, resp_rdata, resp_err, busy,
             mem_valid, mem_rd_wr, mem_addr, mem_din
   );
endinterface

// File: rtl/l2_mem_requester.sv
// L2-to-memory initiator: in-order request FIFO feeding a one-at-a-time memory handshake.
// Define MEM_TIMEOUT_EN to abort requests left unacknowledged for TIMEOUT_CYCLES.
module l2_mem_requester #(
   parameter int ADDR_W         = 14,
   parameter int LINE_W         = 128,
   parameter int FIFO_DEPTH     = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic             clk,
   input logic             rst,
   l2_mem_requester_if.master bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(3);

   typedef struct packed {
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] data;
   } req_t;

   typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

   req_t              fifo_mem [FIFO_DEPTH];
   req_t              head;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count, count_nxt;
   logic              ready_q, push;
   state_t            state, state_nxt;
   logic              issue, done_ack, done_to, to_hit;
   logic              mem_valid_q, mem_rd_wr_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [LINE_W-1:0] mem_din_q, rdata_q;
   logic              resp_valid_q, resp_wr_q;

   assign push      = bus.req_valid && ready_q;
   assign head      = fifo_mem[rd_ptr];
   assign count_nxt = count + (PTR_W+1)'(push) - (PTR_W+1)'(issue);

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= '{wr: bus.req_wr, addr: bus.req_addr, data: bus.req_wdata};
   end

   // req_ready comes from next occupancy, so a pop frees a slot one cycle later
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ready_q <= 1'b1;
      end else begin
         if (push)  wr_ptr <= wr_ptr + 1'b1;
         if (issue) rd_ptr <= rd_ptr + 1'b1;
         count   <= count_nxt;
         ready_q <= (count_nxt != DEPTH_C);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      done_ack  = 1'b0;
      done_to   = 1'b0;
      case (state)
         IDLE: if (count != '0) begin
            issue     = 1'b1;
            state_nxt = REQ;
         end
         REQ: if (bus.mem_ack) begin
            done_ack  = 1'b1;
            state_nxt = RELEASE;
         end else if (to_hit) begin
            done_to   = 1'b1;
            state_nxt = RELEASE;
         end
         RELEASE: if (!bus.mem_ack) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt;
   logic          err_q;

   always_ff @(posedge clk) begin
      if (rst || issue)      tcnt <= '0;
      else if (state == REQ) tcnt <= tcnt + 1'b1;
   end

   // an ack in the timeout cycle wins because done_ack is decoded first
   assign to_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst)           err_q <= 1'b0;
      else if (done_ack) err_q <= 1'b0;
      else if (done_to)  err_q <= 1'b1;
   end
   assign bus.resp_err = err_q;
`else
   assign to_hit       = 1'b0;
   assign bus.resp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_valid_q  <= 1'b0;
         mem_rd_wr_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_din_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_wr_q    <= 1'b0;
         rdata_q      <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         if (issue) begin
            mem_valid_q <= 1'b1;
            mem_rd_wr_q <= head.wr;
            mem_addr_q  <= head.addr & LINE_MASK;
            mem_din_q   <= head.data;
         end
         if (done_ack || done_to) begin
            mem_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_wr_q    <= mem_rd_wr_q;
         end
         if (done_ack && !mem_rd_wr_q) rdata_q <= bus.mem_dout;
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.busy       = (state != IDLE) || (count != '0);
   assign bus.mem_valid  = mem_valid_q;
   assign bus.mem_rd_wr  = mem_rd_wr_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_din    = mem_din_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_wr    = resp_wr_q;
   assign bus.resp_rdata = rdata_q;
endmodule
